// File: rtl/mem_bus_bridge_pkg.sv
// Shared types for the MEM-stage to external bus bridge: FSM encodings,
// bus field widths and the registered bus request record.
package mem_bus_bridge_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    MB_IDLE = 2'd0,
    MB_BUSY = 2'd1,
    MB_DONE = 2'd2
  } mb_state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mb_req_t;

endpackage

// File: rtl/mem_bus_watchdog.sv
// BUSY-cycle watchdog for the bus bridge; expired is high during the
// TIMEOUT_CYCLES-th consecutive counted cycle.
module mem_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at LAST so a stuck count_en never wraps back into range.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (count_en && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = count_en && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges the single-cycle MEM RAM request onto a registered req/ack bus,
// stalling the pipeline until completion. MEM_BUS_TIMEOUT_EN adds a BUSY watchdog.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en,
  input  logic [SEL_W-1:0]  ram_write_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_write_data,
  output logic              stall_req,
  output logic [DATA_W-1:0] ram_read_data,
  output logic              bus_req,
  output logic [SEL_W-1:0]  bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  mb_state_e         state_q, state_d;
  mb_req_t           req_q, req_d;
  logic              bus_req_q, bus_req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wd_expired;

`ifdef MEM_BUS_TIMEOUT_EN
  logic err_q, err_d;

  mem_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == MB_IDLE),
    .count_en (state_q == MB_BUSY),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = |(TIMEOUT_CYCLES ^ CNT_W);
  assign wd_expired = 1'b0;
  assign bus_err    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    bus_req_d = bus_req_q;
    rdata_d   = rdata_q;
`ifdef MEM_BUS_TIMEOUT_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      MB_IDLE: begin
        if (ram_en) begin
          req_d     = '{we: ram_write_en, addr: ram_addr, wdata: ram_write_data};
          bus_req_d = 1'b1;
          state_d   = MB_BUSY;
        end
      end
      MB_BUSY: begin
        // A real ack beats the watchdog on the same cycle.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (req_q.we == '0) rdata_d = bus_rdata;
          state_d   = MB_DONE;
        end else if (wd_expired) begin
          bus_req_d = 1'b0;
          rdata_d   = '0;
`ifdef MEM_BUS_TIMEOUT_EN
          err_d     = 1'b1;
`endif
          state_d   = MB_DONE;
        end
      end
      MB_DONE: begin
        bus_req_d = 1'b0;
        state_d   = MB_IDLE;
      end
      default: begin
        bus_req_d = 1'b0;
        state_d   = MB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MB_IDLE;
      req_q     <= '0;
      bus_req_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      bus_req_q <= bus_req_d;
      rdata_q   <= rdata_d;
    end
  end

  // The pipeline advances during DONE; the next request is taken from IDLE.
  assign stall_req     = ram_en && (state_q != MB_DONE);
  assign ram_read_data = rdata_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = req_q.we;
  assign bus_addr      = req_q.addr;
  assign bus_wdata     = req_q.wdata;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: stimulus queues expected bus requests and
// completions; a negedge monitor checks them as the DUT presents them.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr, ram_write_data;
  logic        stall_req;
  logic [31:0] ram_read_data;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ram_en(ram_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data), .stall_req(stall_req),
    .ram_read_data(ram_read_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct { logic [3:0] we; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] rdata; logic err; int stall; int busy; } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];
  int n_chk = 0, n_pass = 0;
  logic [31:0] model_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: request capture, BUSY stability, and completion in DONE.
  req_t cur;
  logic prev_req = 1'b0;
  int   stall_cnt = 0, req_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0; stall_cnt = 0; req_cnt = 0;
    end else begin
      if (stall_req) stall_cnt++;
      if (bus_req) begin
        if (!prev_req) begin
          if (req_q.size() == 0) chk("unexpected_bus_req", 32'(bus_req), 32'h0);
          else begin
            cur = req_q.pop_front();
            chk("req_we", 32'(bus_we), 32'(cur.we));
            chk("req_addr", bus_addr, cur.addr);
            chk("req_wdata", bus_wdata, cur.wdata);
          end
        end else begin
          chk("busy_stable_we", 32'(bus_we), 32'(cur.we));
          chk("busy_stable_addr", bus_addr, cur.addr);
          chk("busy_stable_wdata", bus_wdata, cur.wdata);
        end
        req_cnt++;
      end else if (prev_req) begin
        if (cmp_q.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
        else begin
          cmp_t c;
          c = cmp_q.pop_front();
          chk("done_rdata", ram_read_data, c.rdata);
          chk("done_err", 32'(bus_err), 32'(c.err));
          chk("stall_cycles", 32'(stall_cnt), 32'(c.stall));
          chk("bus_req_cycles", 32'(req_cnt), 32'(c.busy));
        end
        stall_cnt = 0; req_cnt = 0;
      end
      prev_req = bus_req;
    end
  end

  // ack_wait < 0: no ack, watchdog (4 BUSY cycles) ends the access.
  task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_wait, input logic [31:0] rdata, input bit keep);
    cmp_t c;
    int busy;
    busy = (ack_wait < 0) ? 4 : ack_wait + 1;
    req_q.push_back('{we, addr, wdata});
    if (ack_wait < 0) model_rd = 32'h0;
    else if (we == 4'h0) model_rd = rdata;
    c.rdata = model_rd; c.err = (ack_wait < 0); c.stall = busy + 1; c.busy = busy;
    cmp_q.push_back(c);
    ram_en = 1'b1; ram_write_en = we; ram_addr = addr; ram_write_data = wdata;
    @(posedge clk); #1;
    if (ack_wait >= 0) begin
      repeat (ack_wait) @(posedge clk);
      #1;
      bus_ack = 1'b1; bus_rdata = rdata;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = 32'hBAD0BAD0;
    end else begin
      repeat (4) @(posedge clk);
      #1;
    end
    @(posedge clk); #1;
    if (!keep) begin
      ram_en = 1'b0; ram_write_en = 4'h0; ram_addr = 32'h0; ram_write_data = 32'h0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; ram_en = 1'b0; ram_write_en = 4'h0; ram_addr = 32'h0;
    ram_write_data = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", ram_read_data, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    access(4'h0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    access(4'b0100, 32'h204, 32'h00AB0000, 5, 32'h5555AAAA, 1'b0);
    access(4'h0, 32'h300, 32'h0, 2, 32'hCAFEF00D, 1'b1);
    access(4'b1111, 32'h304, 32'h11223344, 1, 32'h0, 1'b0);

    // Ack while IDLE must be ignored.
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("spurious_ack_req", 32'(bus_req), 32'h0);
    chk("spurious_ack_rdata", ram_read_data, model_rd);
    access(4'h0, 32'h400, 32'h0, 0, 32'h0BADC0DE, 1'b0);

    // Reset mid-BUSY abandons the cycle at once.
    req_q.push_back('{4'h0, 32'h500, 32'h0});
    ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h500; ram_write_data = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1; ram_en = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'h0);
    chk("midrst_bus_addr", bus_addr, 32'h0);
    chk("midrst_rdata", ram_read_data, 32'h0);
    chk("midrst_stall", 32'(stall_req), 32'h0);
    model_rd = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    access(4'h0, 32'h600, 32'h0, 0, 32'h600DF00D, 1'b0);

`ifdef MEM_BUS_TIMEOUT_EN
    access(4'h0, 32'h700, 32'h0, -1, 32'h0, 1'b0);
    access(4'h0, 32'h704, 32'h0, 3, 32'hA5A5A5A5, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("req_queue_drained", 32'(req_q.size()), 32'h0);
    chk("cmp_queue_drained", 32'(cmp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
